// File: rtl/flash_ctrl.sv
// flash_ctrl -- bus-side initiator for the on-chip flash word array.
//
// Accepts one read / write / erase request at a time over a valid/ready
// handshake, drives the flash strobes, supervises the flash busy/error
// handshake, read-back-verifies every write and returns one response per
// request.
//
// Ports
//   clk, RST                 clock (rising edge), async active-high reset
//   req_valid/req_ready      request handshake
//   req_op                   00 read, 01 write, 10 erase, 11 illegal
//   req_addr, req_wdata      word address, write data
//   resp_valid/resp_ready    response handshake (held until accepted)
//   resp_rdata               read data (0 for write/erase)
//   resp_err                 0 OK, 1 RANGE, 2 NOT_ERASED, 3 VERIFY,
//                            4 TIMEOUT, 5 BAD_OP
//   f_rd_en/f_wr_en/f_erase_en  registered one-cycle flash strobes
//   f_addr, f_idata          latched address / write data to flash
//   f_odata                  flash read data (cycle after f_rd_en)
//   f_busy                   flash post-write/erase busy pulse
//   f_error                  write-to-non-erased flag (cycle after f_wr_en)
`timescale 1ns/1ps

module flash_ctrl #(
  parameter int unsigned AW           = 12,
  parameter int unsigned DW           = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic [2:0]    resp_err,
  output logic          f_rd_en,
  output logic          f_wr_en,
  output logic          f_erase_en,
  output logic [AW-1:0] f_addr,
  output logic [DW-1:0] f_idata,
  input  logic [DW-1:0] f_odata,
  input  logic          f_busy,
  input  logic          f_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_STB, S_RD_CAP, S_WR_STB, S_WR_CHK, S_BSY_HI, S_BSY_LO,
    S_VF_STB, S_VF_CAP, S_ER_STB, S_RESP
  } state_t;

  typedef enum logic [2:0] {
    E_OK         = 3'd0,
    E_RANGE      = 3'd1,
    E_NOT_ERASED = 3'd2,
    E_VERIFY     = 3'd3,
    E_TIMEOUT    = 3'd4,
    E_BAD_OP     = 3'd5
  } err_t;

  localparam int unsigned    CW       = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  state_t        r_state;
  state_t        r_ret;        // where BSY_LO goes when the busy pulse ends
  err_t          r_err;
  logic [CW-1:0] r_cnt;
  logic          r_resp_valid;
  logic [DW-1:0] r_rdata;
  logic          r_rd_en;
  logic          r_wr_en;
  logic          r_er_en;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic          w_in_range;
  logic          w_cnt_done;

  // Compare in 64 bits so a DEPTH that is not representable in AW bits
  // still behaves (every address in range).
  assign w_in_range = 64'(req_addr) < 64'(DEPTH);
  assign w_cnt_done = (r_cnt == CNT_LAST);

  // Combinational so the controller is ready in the very first cycle after
  // RST falls, and never while RST is high.
  assign req_ready  = (r_state == S_IDLE) && !RST;

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign f_rd_en    = r_rd_en;
  assign f_wr_en    = r_wr_en;
  assign f_erase_en = r_er_en;
  assign f_addr     = r_addr;
  assign f_idata    = r_wdata;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_ret        <= S_RESP;
      r_err        <= E_OK;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_er_en      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      // Strobes are set only on the transition into their strobe state,
      // so each is a single-cycle pulse.
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_er_en <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= E_OK;
            if (req_op == 2'b11) begin
              r_err        <= E_BAD_OP;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else if (!w_in_range) begin
              r_err        <= E_RANGE;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else if (req_op == 2'b00) begin
              r_rd_en <= 1'b1;
              r_state <= S_RD_STB;
            end else if (req_op == 2'b01) begin
              r_wr_en <= 1'b1;
              r_state <= S_WR_STB;
            end else begin
              r_er_en <= 1'b1;
              r_state <= S_ER_STB;
            end
          end
        end

        S_RD_STB: r_state <= S_RD_CAP;

        S_RD_CAP: begin
          r_rdata      <= f_odata;
          r_err        <= E_OK;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end

        S_WR_STB: r_state <= S_WR_CHK;

        S_WR_CHK: begin
          if (f_error) begin
            r_err        <= E_NOT_ERASED;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_ret   <= S_VF_STB;
            r_cnt   <= '0;
            r_state <= S_BSY_HI;
          end
        end

        S_ER_STB: begin
          r_ret   <= S_RESP;
          r_cnt   <= '0;
          r_state <= S_BSY_HI;
        end

        S_BSY_HI: begin
          if (f_busy) begin
            r_cnt   <= '0;
            r_state <= S_BSY_LO;
          end else if (w_cnt_done) begin
            r_err        <= E_TIMEOUT;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_BSY_LO: begin
          if (!f_busy) begin
            if (r_ret == S_VF_STB) begin
              r_rd_en <= 1'b1;
              r_state <= S_VF_STB;
            end else begin
              r_err        <= E_OK;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end
          end else if (w_cnt_done) begin
            r_err        <= E_TIMEOUT;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_VF_STB: r_state <= S_VF_CAP;

        S_VF_CAP: begin
          r_err        <= (f_odata != r_wdata) ? E_VERIFY : E_OK;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end

        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_ctrl.sv
// Self-checking bench for flash_ctrl: a behavioural flash model, directed
// requests with hand-computed expectations pushed to a scoreboard, and a
// monitor that pops and compares on each new response.
`timescale 1ns/1ps

module tb_flash_ctrl;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic [2:0]  resp_err;
  logic        f_rd_en, f_wr_en, f_erase_en;
  logic [11:0] f_addr;
  logic [31:0] f_idata;
  logic [31:0] f_odata = '0;
  logic        f_busy = 1'b0;
  logic        f_error = 1'b0;

  // flash model knobs
  logic        preload = 1'b1;
  logic        no_busy = 1'b0;   // erase produces no busy pulse
  logic        stick   = 1'b0;   // busy stays high once raised
  logic        corrupt = 1'b0;   // write stores data with bit 0 flipped
  logic        b1 = 1'b0;
  logic [31:0] mem [0:4095];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  err;
    int          lat;
    int          nrd;
    int          nwr;
    int          ner;
  } exp_t;

  exp_t sb[$];

  flash_ctrl #(.AW(12), .DW(32), .DEPTH(1024), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .f_rd_en(f_rd_en), .f_wr_en(f_wr_en), .f_erase_en(f_erase_en),
    .f_addr(f_addr), .f_idata(f_idata), .f_odata(f_odata),
    .f_busy(f_busy), .f_error(f_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash model: read data and error flag one cycle after the strobe,
  // busy pulse two cycles after a successful write or an erase.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      mem[5]    <= 32'hDEADBEEF;
      mem[1023] <= 32'hA5A50F0F;
    end
    f_error <= 1'b0;
    b1      <= 1'b0;
    f_busy  <= b1 | (stick & f_busy);
    if (f_rd_en) f_odata <= mem[f_addr];
    if (f_wr_en) begin
      if (mem[f_addr] != 32'hFFFFFFFF) f_error <= 1'b1;
      else begin
        mem[f_addr] <= corrupt ? (f_idata ^ 32'h1) : f_idata;
        b1 <= 1'b1;
      end
    end
    if (f_erase_en) begin
      mem[f_addr] <= 32'hFFFFFFFF;
      b1 <= !no_busy;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobe hygiene and scoreboard comparison on each new response.
  int   hs_cyc = 0;
  int   n_rd = 0, n_wr = 0, n_er = 0;
  logic seen = 1'b0;
  logic prev_stb = 1'b0;

  always @(negedge clk) begin
    logic stb;
    exp_t e;
    if (RST) begin
      seen     = 1'b0;
      prev_stb = 1'b0;
      n_rd = 0; n_wr = 0; n_er = 0;
    end else begin
      if (req_valid && req_ready) begin
        hs_cyc = cyc;
        n_rd = 0; n_wr = 0; n_er = 0;
      end
      stb = f_rd_en | f_wr_en | f_erase_en;
      if (stb) begin
        checks++;
        if (prev_stb || f_busy || (32'(f_rd_en) + 32'(f_wr_en) + 32'(f_erase_en) > 1)) begin
          errors++;
          $display("FAIL strobe_spacing: prev=%0b busy=%0b rd=%0b wr=%0b er=%0b, required isolated strobe (cycle %0d)",
                   prev_stb, f_busy, f_rd_en, f_wr_en, f_erase_en, cyc);
        end
      end
      prev_stb = stb;
      n_rd += 32'(f_rd_en);
      n_wr += 32'(f_wr_en);
      n_er += 32'(f_erase_en);
      if (resp_valid && !seen) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: err=%0d rdata=0x%0h, required no response (cycle %0d)",
                   resp_err, resp_rdata, cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("resp_latency", 32'(cyc - hs_cyc), 32'(e.lat));
          chk("n_rd_strobes", 32'(n_rd), 32'(e.nrd));
          chk("n_wr_strobes", 32'(n_wr), 32'(e.nwr));
          chk("n_er_strobes", 32'(n_er), 32'(e.ner));
        end
      end
      seen = resp_valid && !resp_ready;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input bit push, input logic [31:0] erd, input logic [2:0] eerr,
                       input int elat, input int enrd, input int enwr, input int ener);
    int n = 0;
    if (push) sb.push_back('{rdata: erd, err: eerr, lat: elat, nrd: enrd, nwr: enwr, ner: ener});
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && n < 200) begin n++; @(negedge clk); end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_wait: got 0, required 1 within 200 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || resp_valid) && n < 200) begin n++; @(negedge clk); end
    if (sb.size() != 0 || resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_wait: pending=%0d valid=%0b, required drained within 200 cycles", sb.size(), resp_valid);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_resp_err"}, 32'(resp_err), 0);
    chk({tag, "_strobes"}, 32'({f_rd_en, f_wr_en, f_erase_en}), 0);
    chk({tag, "_f_addr"}, 32'(f_addr), 0);
    chk({tag, "_f_idata"}, f_idata, 0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk_idle_outputs("rst");
    @(posedge clk); #1 RST = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 1);

    // read preloaded word
    issue(2'b00, 12'd5, 32'h0, 1, 32'hDEADBEEF, 3'd0, 3, 1, 0, 0);  wait_done();
    // erase then write then read back
    issue(2'b10, 12'd7, 32'h0, 1, 32'h0, 3'd0, 5, 0, 0, 1);         wait_done();
    issue(2'b01, 12'd7, 32'h12345678, 1, 32'h0, 3'd0, 7, 1, 1, 0);  wait_done();
    issue(2'b00, 12'd7, 32'h0, 1, 32'h12345678, 3'd0, 3, 1, 0, 0);  wait_done();
    // write over programmed word: NOT_ERASED, no verify read, word unchanged
    issue(2'b01, 12'd7, 32'h1, 1, 32'h0, 3'd2, 3, 0, 1, 0);         wait_done();
    issue(2'b00, 12'd7, 32'h0, 1, 32'h12345678, 3'd0, 3, 1, 0, 0);  wait_done();
    // range boundary and illegal op
    issue(2'b00, 12'd1024, 32'h0, 1, 32'h0, 3'd1, 1, 0, 0, 0);      wait_done();
    issue(2'b01, 12'hFFF, 32'h55, 1, 32'h0, 3'd1, 1, 0, 0, 0);      wait_done();
    issue(2'b11, 12'd3, 32'h0, 1, 32'h0, 3'd5, 1, 0, 0, 0);         wait_done();
    issue(2'b00, 12'd1023, 32'h0, 1, 32'hA5A50F0F, 3'd0, 3, 1, 0, 0); wait_done();

    // busy never rises after erase: 16 cycles in BSY_HI (cycles 2..17)
    no_busy = 1'b1;
    issue(2'b10, 12'd9, 32'h0, 1, 32'h0, 3'd4, 18, 0, 0, 1);        wait_done();
    no_busy = 1'b0;
    // verify mismatch on a corrupted write
    corrupt = 1'b1;
    issue(2'b01, 12'd9, 32'hCAFEF00D, 1, 32'h0, 3'd3, 7, 1, 1, 0);  wait_done();
    corrupt = 1'b0;
    // busy stuck high: 16 cycles in BSY_LO (cycles 4..19)
    stick = 1'b1;
    issue(2'b10, 12'd10, 32'h0, 1, 32'h0, 3'd4, 20, 0, 0, 1);       wait_done();
    stick = 1'b0;
    repeat (3) @(posedge clk);

    // response held with resp_ready low
    #1 resp_ready = 1'b0;
    issue(2'b00, 12'd5, 32'h0, 1, 32'hDEADBEEF, 3'd0, 3, 1, 0, 0);
    begin
      int n = 0;
      @(negedge clk);
      while (!resp_valid && n < 50) begin n++; @(negedge clk); end
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(resp_valid), 1);
      chk("hold_rdata", resp_rdata, 32'hDEADBEEF);
      chk("hold_err", 32'(resp_err), 0);
      chk("hold_req_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_done();

    // reset in the middle of a write: no response
    issue(2'b10, 12'd12, 32'h0, 1, 32'h0, 3'd0, 5, 0, 0, 1);        wait_done();
    issue(2'b01, 12'd12, 32'h87654321, 0, 32'h0, 3'd0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 RST = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 0);
    chk_idle_outputs("midrst");
    @(posedge clk); #1 RST = 1'b0;
    @(negedge clk);
    chk("after_rst_req_ready", 32'(req_ready), 1);
    chk_idle_outputs("after_rst");
    repeat (4) @(posedge clk);

    // controller usable after the abort
    issue(2'b00, 12'd7, 32'h0, 1, 32'h12345678, 3'd0, 3, 1, 0, 0);  wait_done();
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_ctrl.md
# flash_ctrl

Bus-side initiator for the on-chip `flash` word array: accepts single-word read, write and erase requests from the MCU over a valid/ready handshake and sequences the flash strobe ports. It checks every write and erase completion against the flash busy/error handshake and read-back-verifies every write. It returns one response per request with data and an error code. Sits between the MCU memory interconnect and the flash macro.

## Interface
- `AW`, 12: address width, shared by the bus and flash sides.
- `DW`, 32: data width.
- `DEPTH`, 1024: implemented words; addresses `>= DEPTH` are rejected.
- `BUSY_TIMEOUT`, 16: maximum cycles spent in any busy-wait state.

- `clk`  in  1  clock; all logic is clocked on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_op`  in  2  request opcode: 00 read, 01 write, 10 erase, 11 illegal.
- `req_addr`  in  AW  word address.
- `req_wdata`  in  DW  write data.
- `resp_valid`  out  1  response present; held until accepted.
- `resp_ready`  in  1  response accepted.
- `resp_rdata`  out  DW  read data; 0 for write and erase.
- `resp_err`  out  3  response status: 0 OK, 1 RANGE, 2 NOT_ERASED, 3 VERIFY, 4 TIMEOUT, 5 BAD_OP.
- `f_rd_en`, `f_wr_en`, `f_erase_en`  out  1  flash strobes; each is registered and pulses for exactly one cycle.
- `f_addr`  out  AW  flash address; equals the latched address.
- `f_idata`  out  DW  flash write data; equals the latched write data.
- `f_odata`  in  DW  flash read data; valid on the cycle after `f_rd_en`.
- `f_busy`  in  1  flash post-write/erase busy pulse.
- `f_error`  in  1  write-to-non-erased flag; valid on the cycle after `f_wr_en`.

## Operation
- **States:** IDLE, RD_STB, RD_CAP, WR_STB, WR_CHK, BSY_HI, BSY_LO, VF_STB, VF_CAP, ER_STB, RESP.
- **IDLE:**
  - `req_ready` is 1 only in IDLE and is 0 while `RST` is high.
  - On `req_valid && req_ready`, the controller latches op, addr and wdata.
  - An illegal op goes to RESP with BAD_OP.
  - `addr >= DEPTH` goes to RESP with RANGE; no strobe is issued.
  - Otherwise: read goes to RD_STB, write to WR_STB, erase to ER_STB.
- **Read path:** RD_STB (`f_rd_en=1`) goes to RD_CAP. RD_CAP registers `f_odata` into `resp_rdata`, then goes to RESP with OK.
- **Write path:**
  - WR_STB (`f_wr_en=1`) goes to WR_CHK.
  - WR_CHK: if `f_error=1`, go to RESP with NOT_ERASED; otherwise go to BSY_HI with next state VF_STB.
  - VF_STB (`f_rd_en=1`) goes to VF_CAP.
  - VF_CAP: if `f_odata != wdata`, go to RESP with VERIFY; otherwise go to RESP with OK.
- **Erase path:** ER_STB (`f_erase_en=1`) goes to BSY_HI with next state RESP/OK.
- **BSY_HI:** waits for `f_busy=1`, then goes to BSY_LO.
- **BSY_LO:** waits for `f_busy=0`, then goes to the stored next state.
- **Busy-wait timeout:**
  - A wait counter clears on entry to each wait state and increments every cycle in it.
  - Reaching `BUSY_TIMEOUT` goes to RESP with TIMEOUT.
- **RESP:**
  - `resp_valid=1`; `resp_rdata` and `resp_err` are stable.
  - On `resp_ready`, go to IDLE.
  - `req_ready` stays 0 until that cycle has passed, so at most one request is outstanding.
- **Reset:**
  - State goes to IDLE; all strobes, `resp_valid`, `resp_rdata`, `resp_err` and the wait counter go to 0.
  - `f_addr` and `f_idata` go to 0.
- **Reset mid-operation:** aborts with no response. Flash contents already committed are not rolled back.

## Timing
- Cycle 0 is the cycle in which the request handshake occurs.
- **Read:** strobe in cycle 1; `resp_valid` from cycle 3.
- **Write, OK:**
  - cycle 1 WR_STB, cycle 2 WR_CHK, cycle 3 BSY_HI (busy=1), cycle 4 BSY_LO (busy=0).
  - cycle 5 VF_STB, cycle 6 VF_CAP; `resp_valid` from cycle 7.
- **Write, NOT_ERASED:** `resp_valid` from cycle 3; no verify read is issued.
- **Erase:** cycle 1 ER_STB, cycles 2–3 BSY_HI, cycle 4 BSY_LO; `resp_valid` from cycle 5.
- **RANGE / BAD_OP:** `resp_valid` from cycle 1; zero flash strobes.
- **Strobe spacing:** strobes are never asserted in consecutive cycles, and never while `f_busy=1`.
- **Response hold:** `resp_valid` held with `resp_ready=0` keeps the outputs frozen indefinitely; no timeout applies in RESP.

## Test plan
- Flash preloaded with word[5]=0xDEADBEEF; read addr 5 → `resp_valid` in cycle 3, `resp_rdata`=0xDEADBEEF, `resp_err`=0, exactly one `f_rd_en` pulse.
- Erase, then write 0x12345678 to addr 7 → err 0 at cycle 7; a following read of addr 7 returns 0x12345678.
- Write 0x1 to addr 7 again without erasing → err 2 at cycle 3; word stays 0x12345678; no `f_rd_en`.
- Read addr 1024, and issue op 11 → err 1 and err 5 respectively at cycle 1; zero flash strobes.
- Flash model holds `f_busy=0` after erase → err 4 after 16 cycles in BSY_HI.
- Hold `resp_ready=0` for 10 cycles, then assert `RST` mid-write → outputs frozen while held; after reset all outputs are 0 and `req_ready`=1 on the first cycle after `RST` falls.
